// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures an asynchronous PWM input in clock cycles. One measurement is
// reported per complete period (rising edge to rising edge): the period length
// and the number of high cycles within it. An input that produces no rising
// edge for TIMEOUT cycles is reported once as stuck, together with the level
// it is stuck at.
//
// Parameters
//   WIDTH    width of the internal counters and of period/duty
//   TIMEOUT  cycles without a rising edge before the input is declared stuck
//            (2 .. 2**WIDTH-1); also the largest measurable period
//
// Ports
//   clk      system clock, all logic on the rising edge
//   reset    asynchronous, active-low reset
//   pwm_in   asynchronous PWM input
//   valid    one-cycle pulse: period/duty/timeout were updated this cycle
//   period   measured period in cycles (0 on a stuck report)
//   duty     high cycles within the measured period (0 on a stuck report)
//   timeout  high from a stuck report until the next accepted rising edge
//   level    synchronized input level captured at the stuck report
//
// Handshake: valid is a strobe with no back-pressure. period, duty, timeout
// and level are meaningful in the cycle valid is high and hold their values
// until the next valid pulse (timeout additionally clears on the rising edge
// that ends a stuck episode).
// -----------------------------------------------------------------------------
module pwm_capture #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic             valid,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty,
    output logic             timeout,
    output logic             level
);

    // WAIT    : after reset; the first (partial) period is never reported
    // MEASURE : every rising edge reports the period that just ended
    // STUCK   : a stuck report was made; counters frozen until the next edge
    localparam logic [1:0] ST_WAIT    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STUCK   = 2'd2;

    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

    logic             s1;
    logic             s2;
    logic             prev;
    logic             rise;
    logic             at_limit;
    logic [1:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hi;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise     = s2 & ~prev;
    assign at_limit = (cnt == TIMEOUT_CNT);

    // cnt counts cycles since the last rising edge (1 in the cycle after the
    // edge); hi counts synchronized high cycles over the same span, the edge
    // cycle itself included. A rising edge wins over the timeout, so the
    // counters stop at TIMEOUT and never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_WAIT;
            cnt     <= '0;
            hi      <= '0;
            valid   <= 1'b0;
            period  <= '0;
            duty    <= '0;
            timeout <= 1'b0;
            level   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_WAIT, ST_MEASURE: begin
                    if (rise) begin
                        if (state == ST_MEASURE) begin
                            valid   <= 1'b1;
                            period  <= cnt;
                            duty    <= hi;
                            timeout <= 1'b0;
                        end
                        cnt   <= CNT_ONE;
                        hi    <= CNT_ONE;
                        state <= ST_MEASURE;
                    end else if (at_limit) begin
                        // Single stuck report; counters hold at TIMEOUT.
                        valid   <= 1'b1;
                        period  <= '0;
                        duty    <= '0;
                        timeout <= 1'b1;
                        level   <= s2;
                        state   <= ST_STUCK;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        hi  <= hi + WIDTH'(s2);
                    end
                end
                ST_STUCK: begin
                    // The period ending at this edge is incomplete: restart
                    // quietly and resume measuring.
                    if (rise) begin
                        cnt     <= CNT_ONE;
                        hi      <= CNT_ONE;
                        timeout <= 1'b0;
                        state   <= ST_MEASURE;
                    end
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule
